// File: rtl/mips_idmem.sv
// Unified instruction/data memory for the multi-cycle MIPS core, with a
// boot loader that streams words into RAM and a small memory-mapped I/O page.
module mips_idmem #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] adr,
    input  logic [31:0] b,
    output logic [31:0] readData,
    input  logic        boot_valid,
    input  logic [31:0] boot_data,
    input  logic        boot_last,
    output logic        boot_ready,
    output logic        core_hold,
    input  logic [15:0] switches,
    output logic [15:0] leds,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [15:0]   leds_q, leds_d;
    logic [31:0]   cyc_q, cyc_d;
    logic          mis_q, mis_d;
    logic [15:0]   sw_meta_q, sw_meta_d;
    logic [15:0]   sw_sync_q, sw_sync_d;

    logic [31:0]   mem [DEPTH];

    logic          run;
    logic          boot_hs;
    logic          io_sel;
    logic [5:0]    io_off;
    logic [AW-1:0] ram_idx;
    logic          st_run;
    logic          ram_we;
    logic          led_we;
    logic          mis_set;
    logic          mis_clr;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (state_q == BOOT && boot_hs && (boot_last || ptr_q == AW'(DEPTH - 1)))
            state_d = RUN;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        core_hold  = (state_q == BOOT);
        boot_ready = (state_q == BOOT);
    end

    // ---------------- Request decode ----------------
    always_comb begin
        run     = (state_q == RUN);
        boot_hs = boot_ready && boot_valid;
        io_sel  = (adr[31:8] == 24'hFFFFFF);
        io_off  = adr[7:2];
        ram_idx = adr[AW+1:2];
        st_run  = run && memwrite;
        ram_we  = st_run && !io_sel && (adr[1:0] == 2'b00);
        mis_set = st_run && !io_sel && (adr[1:0] != 2'b00);
        led_we  = st_run && io_sel && (io_off == 6'h00);
        mis_clr = st_run && io_sel && (io_off == 6'h03) && b[0];
    end

    // ---------------- Register next-state ----------------
    always_comb begin
        ptr_d     = ptr_q;
        leds_d    = leds_q;
        cyc_d     = cyc_q;
        mis_d     = mis_q;
        sw_meta_d = switches;
        sw_sync_d = sw_meta_q;
        if (boot_hs) ptr_d = ptr_q + AW'(1);
        if (led_we)  leds_d = b[15:0];
        if (run)     cyc_d = cyc_q + 32'd1;
        // a set event outranks a clear landing on the same edge
        if (mis_set)      mis_d = 1'b1;
        else if (mis_clr) mis_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q     <= '0;
            leds_q    <= '0;
            cyc_q     <= '0;
            mis_q     <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            leds_q    <= leds_d;
            cyc_q     <= cyc_d;
            mis_q     <= mis_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    // RAM has no reset so boot images survive a core reset
    always_ff @(posedge clk) begin
        if (boot_hs)     mem[ptr_q]   <= boot_data;
        else if (ram_we) mem[ram_idx] <= b;
    end

    // ---------------- Read mux (zero-latency) ----------------
    always_comb begin
        readData = '0;
        if (run) begin
            if (io_sel) begin
                case (io_off)
                    6'h00:   readData = {16'b0, leds_q};
                    6'h01:   readData = {16'b0, sw_sync_q};
                    6'h02:   readData = cyc_q;
                    6'h03:   readData = {31'b0, mis_q};
                    default: readData = '0;
                endcase
            end else begin
                readData = mem[ram_idx];
            end
        end
    end

    assign leds       = leds_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_mips_idmem.sv
// Self-checking bench for mips_idmem: spec-level model compared every cycle,
// plus directed checks with literal expectations and a DEPTH=4 overflow boot.
module tb_mips_idmem;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memwrite;
    logic [31:0] adr, b, readData;
    logic        boot_valid, boot_last, boot_ready, core_hold;
    logic [31:0] boot_data;
    logic [15:0] switches, leds;
    logic        misaligned;

    logic        o_rst_n, o_memwrite, o_boot_valid, o_boot_last, o_boot_ready, o_core_hold, o_mis;
    logic [31:0] o_adr, o_b, o_rd, o_boot_data;
    logic [15:0] o_sw, o_leds;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_idmem #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst_n), .memwrite(memwrite), .adr(adr), .b(b),
        .readData(readData), .boot_valid(boot_valid), .boot_data(boot_data),
        .boot_last(boot_last), .boot_ready(boot_ready), .core_hold(core_hold),
        .switches(switches), .leds(leds), .misaligned(misaligned)
    );

    mips_idmem #(.DEPTH(4)) dut4 (
        .clk(clk), .reset(o_rst_n), .memwrite(o_memwrite), .adr(o_adr), .b(o_b),
        .readData(o_rd), .boot_valid(o_boot_valid), .boot_data(o_boot_data),
        .boot_last(o_boot_last), .boot_ready(o_boot_ready), .core_hold(o_core_hold),
        .switches(o_sw), .leds(o_leds), .misaligned(o_mis)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // ---------------- Behavioural model ----------------
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_run;
    int          m_ptr;
    logic [15:0] m_leds, m_sw1, m_sw2;
    logic [31:0] m_cnt;
    bit          m_mis;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 0; m_ptr <= 0; m_leds <= '0; m_cnt <= '0;
            m_mis <= 0; m_sw1 <= '0; m_sw2 <= '0;
        end else begin
            m_sw1 <= switches;
            m_sw2 <= m_sw1;
            if (!m_run) begin
                if (boot_valid) begin
                    m_mem[m_ptr]   <= boot_data;
                    m_known[m_ptr] <= 1;
                    m_ptr          <= (m_ptr + 1) % DEPTH;
                    if (boot_last || m_ptr == DEPTH - 1) m_run <= 1;
                end
            end else begin
                m_cnt <= m_cnt + 1;
                if (memwrite) begin
                    if (adr[31:8] == 24'hFFFFFF) begin
                        if (adr[7:2] == 0) m_leds <= b[15:0];
                        if (adr[7:2] == 3 && b[0]) m_mis <= 0;
                    end else if (adr[1:0] != 0) begin
                        m_mis <= 1;
                    end else begin
                        m_mem[adr[7:2]]   <= b;
                        m_known[adr[7:2]] <= 1;
                    end
                end
            end
        end
    end

    // ---------------- Per-cycle compare ----------------
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        bit          rd_ok;
        rd_ok  = 1;
        exp_rd = '0;
        if (m_run) begin
            if (adr[31:8] == 24'hFFFFFF) begin
                case (adr[7:2])
                    0:       exp_rd = {16'b0, m_leds};
                    1:       exp_rd = {16'b0, m_sw2};
                    2:       exp_rd = m_cnt;
                    3:       exp_rd = {31'b0, m_mis};
                    default: exp_rd = '0;
                endcase
            end else begin
                rd_ok  = m_known[adr[7:2]];
                exp_rd = m_mem[adr[7:2]];
            end
        end
        chk("cyc_core_hold", {31'b0, core_hold}, {31'b0, !m_run});
        chk("cyc_boot_ready", {31'b0, boot_ready}, {31'b0, !m_run});
        chk("cyc_leds", {16'b0, leds}, {16'b0, m_leds});
        chk("cyc_misaligned", {31'b0, misaligned}, {31'b0, m_mis});
        if (rd_ok) chk("cyc_readData", readData, exp_rd);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_bus();
        memwrite = 0; adr = '0; b = '0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1; adr = a; b = d;
        cyc();
        idle_bus();
    endtask

    task automatic boot_word(input logic [31:0] d, input logic last);
        boot_valid = 1; boot_data = d; boot_last = last;
        cyc();
        boot_valid = 0; boot_last = 0;
    endtask

    initial begin
        logic [31:0] c1;
        int acc;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        rst_n = 0; o_rst_n = 0;
        idle_bus();
        boot_valid = 0; boot_data = '0; boot_last = 0; switches = '0;
        o_memwrite = 0; o_adr = '0; o_b = '0; o_boot_valid = 0; o_boot_data = '0;
        o_boot_last = 0; o_sw = '0;
        #1;
        chk("rst_core_hold", {31'b0, core_hold}, 32'd1);
        chk("rst_boot_ready", {31'b0, boot_ready}, 32'd1);
        chk("rst_readData", readData, 32'd0);
        cyc();
        rst_n = 1;
        cyc();

        // boot three words with an idle gap
        boot_word(32'h20080005, 0);
        boot_word(32'h20090007, 0);
        cyc();
        boot_valid = 1; boot_data = 32'hAC080040; boot_last = 1;
        #1 chk("boot_hold_before_last", {31'b0, core_hold}, 32'd1);
        cyc();
        boot_valid = 0; boot_last = 0;
        chk("boot_hold_after_last", {31'b0, core_hold}, 32'd0);
        chk("boot_ready_after_last", {31'b0, boot_ready}, 32'd0);
        adr = 32'h8;
        #1 chk("boot_rd_8", readData, 32'hAC080040);
        adr = 32'h0;
        #1 chk("boot_rd_0", readData, 32'h20080005);
        cyc();

        // RAM store/load, same-cycle read returns old data
        store(32'h40, 32'h11111111);
        memwrite = 1; adr = 32'h40; b = 32'h12345678;
        #1 chk("ram_same_cycle_old", readData, 32'h11111111);
        cyc();
        idle_bus(); adr = 32'h40;
        #1 chk("ram_next_cycle_new", readData, 32'h12345678);
        adr = 32'h140;
        #1 chk("ram_alias_140", readData, 32'h12345678);
        cyc();

        // I/O page
        store(32'hFFFFFF00, 32'h0000ABCD);
        chk("io_leds", {16'b0, leds}, 32'h0000ABCD);
        adr = 32'hFFFFFF00;
        #1 chk("io_leds_rd", readData, 32'h0000ABCD);
        switches = 16'h00F0; adr = 32'hFFFFFF04;
        cyc();
        chk("io_sw_one_edge", readData, 32'h0);
        cyc();
        chk("io_sw_two_edges", readData, 32'h000000F0);
        adr = 32'hFFFFFF08;
        #1 c1 = readData;
        repeat (5) cyc();
        chk("io_cnt_delta", readData - c1, 32'd5);
        store(32'hFFFFFF40, 32'hFFFFFFFF);
        adr = 32'hFFFFFF40;
        #1 chk("io_unmapped_rd", readData, 32'h0);

        // misaligned stores
        store(32'h42, 32'hDEADBEEF);
        chk("mis_set", {31'b0, misaligned}, 32'd1);
        adr = 32'h40;
        #1 chk("mis_ram_unchanged", readData, 32'h12345678);
        adr = 32'hFFFFFF0C;
        #1 chk("mis_status_rd", readData, 32'd1);
        store(32'hFFFFFF0C, 32'h0);
        chk("mis_clr_b0_zero", {31'b0, misaligned}, 32'd1);
        store(32'hFFFFFF0C, 32'h1);
        chk("mis_cleared", {31'b0, misaligned}, 32'd0);
        store(32'hFFFFFF03, 32'h0);
        chk("mis_io_no_set", {31'b0, misaligned}, 32'd0);
        store(32'h41, 32'h0);
        store(32'hFFFFFF0C, 32'h1);
        store(32'h43, 32'h0);
        chk("mis_set_after_clr", {31'b0, misaligned}, 32'd1);

        // asynchronous reset mid-run, then one-word reboot
        #2 rst_n = 0;
        #1;
        chk("rst2_core_hold", {31'b0, core_hold}, 32'd1);
        chk("rst2_leds", {16'b0, leds}, 32'h0);
        chk("rst2_mis", {31'b0, misaligned}, 32'h0);
        chk("rst2_cnt", dut.cyc_q, 32'h0);
        cyc();
        rst_n = 1;
        cyc();
        boot_word(32'hCAFEF00D, 1);
        adr = 32'hFFFFFF08;
        #1 chk("rst2_cnt_first_run", readData, 32'h0);
        adr = 32'h0;
        #1 chk("rst2_rd_0", readData, 32'hCAFEF00D);
        adr = 32'h4;
        #1 chk("rst2_rd_4", readData, 32'h20090007);
        adr = 32'h40;
        #1 chk("rst2_rd_40", readData, 32'h12345678);
        cyc();

        // DEPTH=4 overflow: six words offered, four taken
        o_rst_n = 1;
        cyc();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            o_boot_valid = 1; o_boot_data = 32'hA0 + i;
            #1 if (o_boot_ready) acc++;
            cyc();
        end
        o_boot_valid = 0;
        chk("ovf_accepted", acc, 32'd4);
        chk("ovf_hold", {31'b0, o_core_hold}, 32'd0);
        chk("ovf_ready", {31'b0, o_boot_ready}, 32'd0);
        o_adr = 32'h0;
        #1 chk("ovf_rd_0", o_rd, 32'hA0);
        o_adr = 32'hC;
        #1 chk("ovf_rd_c", o_rd, 32'hA3);
        o_adr = 32'h10;
        #1 chk("ovf_alias_10", o_rd, 32'hA0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_idmem.md
# mips_idmem

Unified instruction/data memory and responder for the multi-cycle MIPS core's memory port. It answers the core's `adr`/`memwrite`/`b` requests with `readData` from a word-addressed RAM or a small memory-mapped I/O page. A boot loader fills the RAM over a valid/ready stream and holds the core in reset (`core_hold`) until loading is complete. It sits beside the core in the top level, replacing the memory that was previously embedded with it.

## Interface
- `DEPTH`, 64: RAM size in 32-bit words; power of two, 4..4096.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `memwrite` in 1: core store strobe.
- `adr` in 32: core byte address.
- `b` in 32: core store data.
- `readData` out 32: load/fetch data to core, combinational.
- `boot_valid` in 1: boot word offered.
- `boot_data` in 32: boot word.
- `boot_last` in 1: offered word is the final one.
- `boot_ready` out 1: loader accepts a word this cycle.
- `core_hold` out 1: keep core in reset; top ORs it into the core's reset.
- `switches` in 16: asynchronous board inputs.
- `leds` out 16: LED register.
- `misaligned` out 1: sticky misaligned-store flag.

## Operation
- **FSM states:** BOOT, RUN. Reset enters BOOT; RUN persists until the next reset.
- **BOOT:**
  - `core_hold`=1 and `boot_ready`=1.
  - A handshake occurs when `boot_valid` and `boot_ready` are both high. On a handshake: `mem[ptr]<=boot_data`, `ptr<=ptr+1`.
  - Go to RUN on the edge after accepting a word with `boot_last`=1, or after accepting the word at `ptr==DEPTH-1`, whichever comes first.
  - `memwrite` is ignored; `readData`=0.
- **RUN:**
  - `core_hold`=0 and `boot_ready`=0; boot inputs are ignored.
- **Address decode (RUN):**
  - `adr[31:8]==24'hFFFFFF` selects the I/O page. All other addresses select RAM at word index `adr[log2(DEPTH)+1:2]`; higher bits alias.
- **I/O page** (decoded on `adr[7:2]`, `adr[1:0]` ignored):
  - 0x00 LED: read/write; reads `{16'b0,leds}`; a store loads `b[15:0]`.
  - 0x04 switches: read-only; reads `{16'b0,sw_sync}`, where `sw_sync` is a 2-flop synchronizer output.
  - 0x08 cycle counter: read-only; 32-bit, increments every RUN cycle, wraps to 0 after FFFFFFFF.
  - 0x0C status: bit0 = `misaligned`, other bits read 0. A store with `b[0]=1` clears the flag.
  - All other offsets read 0; stores to them are ignored.
- **Stores:**
  - A store to RAM with `adr[1:0]!=0` is suppressed and sets `misaligned`. I/O stores never set it.
  - Loads ignore `adr[1:0]` and never flag.
  - If a clear (status write) and a new set event occur in the same cycle, set wins.
- **Reset (asynchronous, any time, including mid-boot or mid-store):**
  - State returns to BOOT with `ptr`=0, `leds`=0, counter=0, `misaligned`=0, synchronizer flops=0.
  - Outputs during reset: `core_hold`=1, `boot_ready`=1, `readData`=0.
  - RAM contents are not cleared.

## Timing
- `readData` is combinational from `adr` and current state. The core samples it at the end of the same cycle, so load latency is 0 cycles.
- Writes (RAM, LED, status clear, boot) commit on the rising edge.
- A read of an address being written in the same cycle returns the old value; the new value is visible from the next cycle.
- Counter reads return the registered value. The first RUN cycle reads 0.
- Switch changes appear at 0x04 two edges after they become stable.
- `core_hold` falls on the same edge the FSM enters RUN. The core's first fetch happens in the first RUN cycle.
- `boot_ready` is a function of state only; it does not depend on `boot_valid` (no combinational path).
- `misaligned` asserts on the edge after the offending store.

## Test plan
- **Boot with last:** stream 3 words (0x20080005, 0x20090007, 0xAC080040), last on the 3rd, with one idle cycle inserted → RAM[0..2] hold those words; `core_hold` drops on the edge after the 3rd handshake; `readData` at adr 0x8 = 0xAC080040.
- **Boot overflow (DEPTH=4):** offer 6 words with no `boot_last` → exactly 4 accepted; RUN entered; `boot_ready`=0 afterwards; RAM[0] = 1st word.
- **RAM store/load:** in RUN, store 0x12345678 to 0x40 → same-cycle `readData` shows the old value, next cycle shows 0x12345678. With DEPTH=64, a load of 0x140 aliases to 0x40.
- **I/O page:** store 0xABCD to 0xFFFFFF00 → `leds`=0xABCD. Set `switches`=0x00F0 → 0xFFFFFF04 reads 0x000000F0 after 2 edges. Two reads of 0xFFFFFF08 N cycles apart differ by N.
- **Misaligned:** store to 0x42 → RAM unchanged and `misaligned`=1. Store 1 to 0xFFFFFF0C → flag clears. Clear coincident with a new misaligned store → flag stays 1.
- **Reset mid-run:** pull `reset` low asynchronously between edges → `core_hold`=1, `leds`=0, counter=0 immediately; RAM data retained and readable after re-boot of 1 word with last.
